bioee_vector_sequencer: RTL and testbench
=========================================

// Module: bioee_vector_sequencer
// PURPOSE
//   Read-side controller for the 16-bit vector FIFO. Replaces free-running reads with
//   paced playback: primes the FIFO, pops one word per programmable vector period,
//   drives it onto vectoroutput, counts vectors, flags underrun, supports abort.
//   Sits in the vectorclk domain between the FIFO read port and the vector pins.
// PARAMETERS
//   DATA_W      16       vector width (matches FIFO dout)
//   CNT_W       24       width of vector_count / remaining counter
//   DIV_W       16       width of rate_div
//   IDLE_VECTOR 16'h0000 value driven after reset and after abort
// PORTS
//   vectorclk      in   1       sole clock
//   vectorreset_n  in   1       reset, asynchronous, active-low
//   start          in   1       1-cycle pulse: begin playback (ignored while busy)
//   abort          in   1       1-cycle pulse: stop immediately, return to IDLE
//   wait_full      in   1       1: prime until fifo_prog_full; 0: prime until !fifo_empty
//   rate_div       in   DIV_W   vector period = rate_div+1 clocks; sampled at start
//   vector_count   in   CNT_W   vectors to play; 0 = continuous until abort; sampled at start
//   fifo_dout      in   DATA_W  FIFO read data, valid 1 clock after fifo_rd_en
//   fifo_empty     in   1       FIFO empty
//   fifo_prog_full in   1       FIFO programmable-full (priming threshold)
//   fifo_rd_en     out  1       FIFO read strobe, never asserted while fifo_empty=1
//   vectoroutput   out  DATA_W  registered vector output
//   vector_strobe  out  1       1-cycle pulse when vectoroutput updates
//   busy           out  1       state != IDLE
//   done           out  1       1-cycle pulse on normal completion
//   underrun       out  1       sticky: a vector slot found FIFO empty; cleared on start
// BEHAVIOUR
//   Reset: state=IDLE; vectoroutput=IDLE_VECTOR; fifo_rd_en, vector_strobe, busy, done,
//     underrun = 0; divider and remaining counters = 0.
//   States: IDLE -> PRIME -> RUN -> DRAIN -> IDLE.
//   IDLE: start & !abort -> PRIME; latch rate_div, vector_count; clear underrun.
//   PRIME: exit to RUN when (wait_full ? fifo_prog_full : !fifo_empty); divider loaded
//     to 0 so first slot occurs on the first RUN cycle.
//   RUN: divider counts down; at 0 (slot) it reloads rate_div.
//     Slot & !fifo_empty: fifo_rd_en=1 for that cycle; remaining-- (unless continuous).
//     Next cycle: vectoroutput<=fifo_dout, vector_strobe=1. Latency rd_en->output = 1.
//     Slot & fifo_empty: no read, underrun<=1, vectoroutput holds, remaining unchanged
//     (slot is lost, not retried early); playback continues.
//     Last read issued (remaining 1->0, finite mode) -> DRAIN.
//   DRAIN: one cycle for final load/strobe; done=1 in that same cycle; -> IDLE.
//   rate_div=0: one read per clock, back-to-back; strobes every clock while data present.
//   abort (any non-IDLE state, highest priority): -> IDLE next edge; vectoroutput<=IDLE_VECTOR;
//     no strobe, no done; a read issued the previous cycle is consumed and discarded.
//   start & abort same cycle: abort wins, stays IDLE. start while busy: ignored.
//   Mid-run changes on rate_div/vector_count have no effect until next start.
//   Counter arithmetic: unsigned, no wrap; remaining never decremented below 0.
//   vectoroutput retains last vector after done.
// STRUCTURE
//   bioee_vector_defs.vh: state encodings (IDLE/PRIME/RUN/DRAIN), default widths,
//     IDLE_VECTOR default; shared with the PC-side vector block.
//   Sub-module bioee_rate_divider: DIV_W down-counter, load/enable, 1-cycle tick at 0.
//   Top holds FSM, remaining counter, rd_en->load pipeline register, output register.
// TESTING
//   1 rate_div=3, count=4, FIFO preloaded 0x1111..0x4444, wait_full=0 -> strobes 4 clocks
//     apart, outputs 0x1111,0x2222,0x3333,0x4444; done pulse with last strobe; 4 reads total.
//   2 rate_div=0, count=8, 8 words -> 8 consecutive rd_en, 8 consecutive strobes, no underrun.
//   3 rate_div=2, count=3, only 2 words then 3rd written late -> underrun=1 at empty slot,
//     output holds 2nd word, 3rd word played at later slot, done; underrun cleared on next start.
//   4 wait_full=1, prog_full low -> stays PRIME, no rd_en; raise prog_full -> first rd_en next cycle.
//   5 count=0 continuous, abort after 5 strobes -> IDLE next edge, vectoroutput=0x0000, no done.
//   6 async vectorreset_n low mid-RUN -> all outputs to reset values without clock; start+abort
//     same cycle -> busy stays 0.

Source files
------------

// File: rtl/bioee_vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bioee_vector_sequencer_pkg
// Description : Shared definitions for the vector playback sequencer:
//               default widths, the idle vector value, the FSM state
//               encodings and the priming-exit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bioee_vector_sequencer_pkg;

  // Default widths; the PC-side vector block uses the same values.
  localparam int unsigned SEQ_DATA_W = 16;
  localparam int unsigned SEQ_CNT_W  = 24;
  localparam int unsigned SEQ_DIV_W  = 16;

  // Value on the vector pins after reset and after an abort.
  localparam logic [15:0] SEQ_IDLE_VECTOR = 16'h0000;

  // Playback FSM encodings.
  typedef logic [1:0] seq_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Priming completes either at the programmable-full threshold or as soon
  // as at least one word is present, depending on the selected mode.
  function automatic logic prime_met(input logic wait_full,
                                     input logic prog_full,
                                     input logic empty);
    return wait_full ? prog_full : !empty;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bioee_vector_sequencer_rate_divider.sv
`default_nettype none
// ============================================================================
// Module      : bioee_vector_sequencer_rate_divider
// Description : DIV_W-bit down-counter that marks vector slots. A load forces
//               the count (used to make the first slot immediate); while
//               enabled the count decrements and, on reaching zero, emits a
//               one-cycle tick and reloads the period value.
// Ports       : clk_i, rst_ni     clock, asynchronous active-low reset
//               load_i/load_val_i force count to load_val_i (priority)
//               en_i              count enable
//               reload_val_i      value reloaded after each tick
//               tick_o            high for the cycle the count is zero and enabled
// Revision    : 1.0 - initial release
// ============================================================================
module bioee_vector_sequencer_rate_divider #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] reload_val_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] count_q, count_d;
  logic             at_zero;

  assign at_zero = (count_q == '0);
  assign tick_o  = en_i && at_zero;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      // Reload on the tick cycle so the period is reload_val_i+1 clocks.
      count_d = at_zero ? reload_val_i : (count_q - DIV_W'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bioee_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bioee_vector_sequencer
// Description : Read-side controller for the vector FIFO. Primes the FIFO,
//               pops one word per programmable vector period, drives it onto
//               the vector pins, counts vectors, flags underrun and supports
//               abort. Single clock domain (vectorclk).
// Ports       : vectorclk, vectorreset_n    clock, async active-low reset
//               start, abort                control pulses (abort dominates)
//               wait_full                   priming mode select
//               rate_div, vector_count      run settings, sampled at start
//               fifo_dout/empty/prog_full   FIFO read-side status and data
//               fifo_rd_en                  FIFO read strobe
//               vectoroutput, vector_strobe registered vector and its update pulse
//               busy, done, underrun        status (done: pulse, underrun: sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module bioee_vector_sequencer
  import bioee_vector_sequencer_pkg::*;
#(
  parameter int unsigned       DATA_W      = SEQ_DATA_W,
  parameter int unsigned       CNT_W       = SEQ_CNT_W,
  parameter int unsigned       DIV_W       = SEQ_DIV_W,
  parameter logic [DATA_W-1:0] IDLE_VECTOR = DATA_W'(SEQ_IDLE_VECTOR)
) (
  input  logic              vectorclk,
  input  logic              vectorreset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              wait_full,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [CNT_W-1:0]  vector_count,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_prog_full,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] vectoroutput,
  output logic              vector_strobe,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  rate_q, rate_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              cont_q, cont_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] vout_q, vout_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;

  logic              rd_en;
  logic              div_load;
  logic              div_en;
  logic              slot;

  bioee_vector_sequencer_rate_divider #(
    .DIV_W (DIV_W)
  ) u_rate_divider (
    .clk_i        (vectorclk),
    .rst_ni       (vectorreset_n),
    .load_i       (div_load),
    .load_val_i   ('0),
    .en_i         (div_en),
    .reload_val_i (rate_q),
    .tick_o       (slot)
  );

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    remaining_d = remaining_q;
    cont_d      = cont_q;
    rd_pend_d   = 1'b0;
    vout_d      = vout_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    rd_en       = 1'b0;
    div_load    = 1'b0;
    div_en      = 1'b0;

    // FIFO data arrives the cycle after the read; capture it then. The
    // strobe and done are registered alongside the data so all three become
    // visible in the same cycle.
    if (rd_pend_q) begin
      vout_d   = fifo_dout;
      strobe_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_PRIME;
          rate_d      = rate_div;
          remaining_d = vector_count;
          cont_d      = (vector_count == '0);
          underrun_d  = 1'b0;
        end
      end
      ST_PRIME: begin
        // Holding the divider at zero makes the first RUN cycle a slot.
        div_load = 1'b1;
        if (prime_met(wait_full, fifo_prog_full, fifo_empty)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        div_en = 1'b1;
        if (slot) begin
          if (!fifo_empty) begin
            rd_en     = 1'b1;
            rd_pend_d = 1'b1;
            if (!cont_q && (remaining_q != '0)) begin
              remaining_d = remaining_q - CNT_W'(1);
              if (remaining_q == CNT_W'(1)) begin
                state_d = ST_DRAIN;
              end
            end
          end else begin
            // Empty slot is dropped, not retried; playback keeps its pace.
            underrun_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything: no new read, any in-flight word discarded.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      rd_en      = 1'b0;
      rd_pend_d  = 1'b0;
      vout_d     = IDLE_VECTOR;
      strobe_d   = 1'b0;
      done_d     = 1'b0;
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge vectorclk or negedge vectorreset_n) begin
    if (!vectorreset_n) begin
      state_q     <= ST_IDLE;
      rate_q      <= '0;
      remaining_q <= '0;
      cont_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      vout_q      <= IDLE_VECTOR;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      remaining_q <= remaining_d;
      cont_q      <= cont_d;
      rd_pend_q   <= rd_pend_d;
      vout_q      <= vout_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign fifo_rd_en    = rd_en;
  assign vectoroutput  = vout_q;
  assign vector_strobe = strobe_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign underrun      = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_bioee_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bioee_vector_sequencer
// Description : Scoreboard bench for the vector sequencer. The stimulus
//               process owns a queue-based FIFO model and pushes expected
//               vectors (value, inter-strobe gap, last flag) plus point
//               checks; the monitor process pops and compares at negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bioee_vector_sequencer;

  localparam int SEL_BUSY  = 0;
  localparam int SEL_VOUT  = 1;
  localparam int SEL_UND   = 2;
  localparam int SEL_RDEN  = 3;
  localparam int SEL_ACT   = 4;
  localparam int SEL_QLEFT = 5;

  typedef struct {
    logic [15:0] data;
    bit          last;
    int          gap;
  } exp_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    logic [31:0] act;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, wait_full;
  logic [15:0] rate_div;
  logic [23:0] vector_count;
  logic [15:0] fifo_dout;
  logic        fifo_empty, fifo_prog_full;
  logic        fifo_rd_en;
  logic [15:0] vectoroutput;
  logic        vector_strobe, busy, done, underrun;

  exp_t        exp_q[$];
  chk_t        chk_q[$];
  logic [15:0] fifo_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_strobe = 0;
  int rd_total = 0;
  bit tb_done = 1'b0;

  bioee_vector_sequencer dut (
    .vectorclk      (clk),
    .vectorreset_n  (rst_n),
    .start          (start),
    .abort          (abort),
    .wait_full      (wait_full),
    .rate_div       (rate_div),
    .vector_count   (vector_count),
    .fifo_dout      (fifo_dout),
    .fifo_empty     (fifo_empty),
    .fifo_prog_full (fifo_prog_full),
    .fifo_rd_en     (fifo_rd_en),
    .vectoroutput   (vectoroutput),
    .vector_strobe  (vector_strobe),
    .busy           (busy),
    .done           (done),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- monitor
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    chk_t        c;
    logic [31:0] a;
    cyc = cyc + 1;
    if (!rst_n) begin
      check("reset_values",
            {11'd0, vectoroutput, vector_strobe, busy, done, underrun, fifo_rd_en},
            32'd0);
    end else begin
      if (vector_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("vector_value", {16'd0, vectoroutput}, {16'd0, e.data});
          check("done_with_strobe", {31'd0, done}, {31'd0, e.last});
          if (e.gap != 0) check("strobe_gap", 32'(cyc - last_strobe), 32'(e.gap));
        end
        last_strobe = cyc;
      end else if (done) begin
        check("done_without_strobe", 32'd1, 32'd0);
      end
      if (fifo_rd_en) check("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sel)
        SEL_BUSY:  a = {31'd0, busy};
        SEL_VOUT:  a = {16'd0, vectoroutput};
        SEL_UND:   a = {31'd0, underrun};
        SEL_RDEN:  a = {31'd0, fifo_rd_en};
        SEL_QLEFT: a = 32'(exp_q.size());
        default:   a = c.act;
      endcase
      check(c.name, a, c.exp);
    end
    if (tb_done) begin
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic push_chk(input string nm, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = nm; c.sel = sel; c.exp = exp; c.act = '0;
    chk_q.push_back(c);
  endtask

  task automatic push_act(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = nm; c.sel = SEL_ACT; c.exp = exp; c.act = act;
    chk_q.push_back(c);
  endtask

  task automatic expect_vec(input logic [15:0] w, input bit last, input int gap);
    exp_t e;
    e.data = w; e.last = last; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    fifo_empty = 1'b1;
  endtask

  // One clock: sample the read strobe at negedge, pop the FIFO model just
  // after the edge so its data is valid during the following cycle.
  task automatic step(input int n = 1);
    logic rd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd = fifo_rd_en;
      if (rd) rd_total++;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic start_run(input int r, input int n, input bit wf);
    rate_div     = 16'(r);
    vector_count = 24'(n);
    wait_full    = wf;
    start        = 1'b1;
    rd_total     = 0;
    step();
    start        = 1'b0;
    // Settings changed mid-run must not affect the current playback.
    rate_div     = 16'($urandom);
    vector_count = 24'($urandom);
    push_chk("underrun_cleared_on_start", SEL_UND, 32'd0);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    if (busy) push_act(nm, 32'd1, 32'd0);
    step(2);
  endtask

  task automatic wait_underrun(input string nm);
    int k;
    k = 0;
    while (!underrun && k < 60) begin
      step();
      k++;
    end
    if (!underrun) push_act(nm, 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : stimulus
    logic [15:0] w, lastw, wb;
    int          r, n, extra, seen;
    bit          wf;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; wait_full = 1'b0;
    rate_div = '0; vector_count = '0; fifo_dout = '0;
    fifo_empty = 1'b1; fifo_prog_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);
    push_chk("idle_after_reset", SEL_BUSY, 32'd0);

    // 1: paced playback, rate_div=3, four vectors, start pulse mid-run ignored
    for (int k = 0; k < 4; k++) begin
      w = 16'h1111 * 16'(k + 1);
      push_word(w);
      expect_vec(w, k == 3, (k == 0) ? 0 : 4);
    end
    start_run(3, 4, 1'b0);
    push_chk("busy_after_start", SEL_BUSY, 32'd1);
    step(6);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t1_timeout");
    push_act("t1_reads", 32'(rd_total), 32'd4);
    push_chk("t1_hold_last", SEL_VOUT, 32'h4444);
    push_chk("t1_no_underrun", SEL_UND, 32'd0);

    // 2: rate_div=0, back-to-back reads and strobes
    for (int k = 0; k < 8; k++) begin
      w = 16'($urandom);
      push_word(w);
      expect_vec(w, k == 7, (k == 0) ? 0 : 1);
    end
    start_run(0, 8, 1'b0);
    wait_idle("t2_timeout");
    push_act("t2_reads", 32'(rd_total), 32'd8);
    push_chk("t2_no_underrun", SEL_UND, 32'd0);

    // 3: underrun on a starved slot, late word played one period later
    w  = 16'hA5A1;
    wb = 16'hA5A2;
    push_word(w);
    push_word(wb);
    expect_vec(w, 1'b0, 0);
    expect_vec(wb, 1'b0, 3);
    expect_vec(16'hA5A3, 1'b1, 6);
    start_run(2, 3, 1'b0);
    wait_underrun("t3_underrun_timeout");
    push_chk("t3_hold_second", SEL_VOUT, {16'd0, wb});
    push_word(16'hA5A3);
    wait_idle("t3_timeout");
    push_chk("t3_underrun_sticky", SEL_UND, 32'd1);
    push_act("t3_reads", 32'(rd_total), 32'd3);

    // 4: wait_full priming holds off reads until prog_full
    for (int k = 0; k < 2; k++) begin
      w = 16'($urandom);
      push_word(w);
      expect_vec(w, k == 1, (k == 0) ? 0 : 2);
    end
    fifo_prog_full = 1'b0;
    start_run(1, 2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      push_chk("t4_prime_no_rd", SEL_RDEN, 32'd0);
      push_chk("t4_prime_busy", SEL_BUSY, 32'd1);
      step();
    end
    fifo_prog_full = 1'b1;
    push_chk("t4_prime_no_rd", SEL_RDEN, 32'd0);
    step();
    push_chk("t4_first_rd", SEL_RDEN, 32'd1);
    wait_idle("t4_timeout");
    fifo_prog_full = 1'b0;
    push_act("t4_reads", 32'(rd_total), 32'd2);

    // 5: continuous mode, abort after five strobes
    for (int k = 0; k < 10; k++) begin
      w = 16'($urandom);
      push_word(w);
      if (k < 5) expect_vec(w, 1'b0, (k == 0) ? 0 : 2);
    end
    start_run(1, 0, 1'b0);
    seen = 0;
    for (int k = 0; k < 60 && seen < 5; k++) begin
      step();
      if (vector_strobe) seen++;
    end
    if (seen < 5) push_act("t5_strobe_timeout", 32'(seen), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    push_chk("t5_idle_after_abort", SEL_BUSY, 32'd0);
    push_chk("t5_idle_vector", SEL_VOUT, 32'h0000);
    step(3);
    push_act("t5_reads", 32'(rd_total), 32'd5);
    flush_fifo();

    // Randomized finite runs against the queue model
    for (int it = 0; it < 10; it++) begin
      r     = int'($urandom_range(0, 4));
      n     = int'($urandom_range(1, 6));
      extra = int'($urandom_range(0, 2));
      wf    = 1'($urandom_range(0, 1));
      fifo_prog_full = wf;
      lastw = '0;
      for (int k = 0; k < n + extra; k++) begin
        w = 16'($urandom);
        push_word(w);
        if (k < n) expect_vec(w, k == n - 1, (k == 0) ? 0 : r + 1);
        if (k == n - 1) lastw = w;
      end
      start_run(r, n, wf);
      wait_idle("rand_timeout");
      push_act("rand_reads", 32'(rd_total), 32'(n));
      push_chk("rand_hold_last", SEL_VOUT, {16'd0, lastw});
      push_chk("rand_no_underrun", SEL_UND, 32'd0);
      flush_fifo();
      fifo_prog_full = 1'b0;
    end

    // 6: asynchronous reset mid-run, then start+abort together
    w  = 16'h0F0F;
    wb = 16'hF0F0;
    push_word(w);
    push_word(wb);
    expect_vec(w, 1'b0, 0);
    expect_vec(wb, 1'b0, 2);
    start_run(1, 0, 1'b0);
    wait_underrun("t6_underrun_timeout");
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
    push_chk("t6_idle_after_reset", SEL_BUSY, 32'd0);
    rate_div = 16'd1;
    vector_count = 24'd3;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    push_chk("t6_start_abort_idle", SEL_BUSY, 32'd0);
    step();
    push_chk("t6_start_abort_idle2", SEL_BUSY, 32'd0);
    push_chk("t6_vector_reset_value", SEL_VOUT, 32'h0000);

    push_chk("all_vectors_seen", SEL_QLEFT, 32'd0);
    step(2);
    tb_done = 1'b1;
  end

endmodule
`default_nettype wire
